wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone B4 classic arbiter: shares one slave (the mem block) between NUM_M masters (e.g. cpu_wb data port plus a DMA/debug master).
- Sits between the masters and the mem slave on the wb_clk domain.
- Grant is held for a master's whole cyc_i burst.
- A bus-timeout watchdog returns err_o to a master whose strobe is never acknowledged.

---
 rtl/wb_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: NUM_M masters share one slave.
// Grant is held for a whole cyc burst; a watchdog errors out unacknowledged strobes.
module wb_rr_arbiter #(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255,
  parameter int TW      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [4*NUM_M-1:0]    m_sel_i,
  input  logic [30*NUM_M-1:0]   m_adr_i,
  input  logic [32*NUM_M-1:0]   m_dat_i,
  output logic [31:0]           m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [29:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_ack_i,
  output logic [NUM_M-1:0]      gnt_o
);

  localparam int IW = $clog2(NUM_M);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t           r_state, w_state_next;
  logic [NUM_M-1:0] r_gnt, w_gnt_next;
  logic [IW-1:0]    r_ptr, w_ptr_next;
  logic [TW-1:0]    r_tcnt, w_tcnt_next;
  logic [IW-1:0]    w_gidx, w_gidx_inc, w_sel;
  logic [IW:0]      w_cand;
  logic             w_found;

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_gnt[i]) w_gidx = IW'(i);
    end
  end

  assign w_gidx_inc = (w_gidx == IW'(NUM_M - 1)) ? '0 : w_gidx + IW'(1);

  // Scan ptr, ptr+1, ... wrapping at NUM_M; first requester wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_cand = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_cand >= (IW+1)'(NUM_M)) w_cand = w_cand - (IW+1)'(NUM_M);
      if (!w_found && m_cyc_i[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    case (r_state)
      BUSY: begin
        s_cyc_o = m_cyc_i[w_gidx];
        s_stb_o = m_stb_i[w_gidx];
        s_we_o  = m_we_i[w_gidx];
        s_sel_o = m_sel_i[w_gidx*4 +: 4];
        s_adr_o = m_adr_i[w_gidx*30 +: 30];
        s_dat_o = m_dat_i[w_gidx*32 +: 32];
        m_ack_o = r_gnt & {NUM_M{s_ack_i}};
      end
      ERR:     m_err_o = r_gnt;
      default: ;
    endcase
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = r_gnt;

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_ptr_next   = r_ptr;
    w_tcnt_next  = r_tcnt;
    case (r_state)
      IDLE: begin
        w_tcnt_next = '0;
        if (w_found) begin
          w_gnt_next   = NUM_M'(1) << w_sel;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (!m_cyc_i[w_gidx]) begin
          w_state_next = IDLE;
          w_gnt_next   = '0;
          w_ptr_next   = w_gidx_inc;
          w_tcnt_next  = '0;
        end else if (s_stb_o && !s_ack_i) begin
          if (r_tcnt == TW'(TIMEOUT - 1)) begin
            w_state_next = ERR;
            w_tcnt_next  = '0;
          end else begin
            w_tcnt_next = r_tcnt + TW'(1);
          end
        end else begin
          w_tcnt_next = '0;
        end
      end
      ERR: begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
        w_ptr_next   = w_gidx_inc;
        w_tcnt_next  = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
        w_tcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_ptr   <= w_ptr_next;
      r_tcnt  <= w_tcnt_next;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, TIMEOUT=8) with a tiny
// combinational-ack memory slave.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [7:0]  m_sel;
  logic [59:0] m_adr;
  logic [63:0] m_dat;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, gnt_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [29:0] s_adr_o;
  logic [31:0] s_dat_o, s_dat_i;
  logic        s_ack_i;
  logic        ack_en, force_ack;
  logic [31:0] mem [0:63];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_M(2), .TIMEOUT(8), .TW(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  assign s_ack_i = (ack_en & s_cyc_o & s_stb_o) | force_ack;
  assign s_dat_i = mem[s_adr_o[5:0]];

  always @(posedge clk) begin
    if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) mem[s_adr_o[5:0]] <= s_dat_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst_i = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
    m_adr = '0; m_dat = '0; ack_en = 1'b0; force_ack = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) step();
    #1;
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_scyc", 32'(s_cyc_o), 32'h0);
    check("rst_ack_err", 32'({m_ack_o, m_err_o}), 32'h0);
    rst_i = 1'b0;

    // Single master write then read-back
    step();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[3:0] = 4'hF;
    m_adr[29:0] = 30'h10; m_dat[31:0] = 32'hDEADBEEF;
    #1 check("t1_idle_scyc", 32'(s_cyc_o), 32'h0);
    step();
    #1;
    check("t1_scyc", 32'(s_cyc_o), 32'h1);
    check("t1_gnt", 32'(gnt_o), 32'h1);
    check("t1_sadr", 32'(s_adr_o), 32'h10);
    check("t1_sdat", s_dat_o, 32'hDEADBEEF);
    check("t1_ack_noack", 32'(m_ack_o), 32'h0);
    ack_en = 1'b1;
    #1 check("t1_ack_wr", 32'(m_ack_o), 32'h1);
    step();
    m_we[0] = 1'b0;
    #1;
    check("t1_ack_rd", 32'(m_ack_o), 32'h1);
    check("t1_rdata", m_dat_o, 32'hDEADBEEF);
    m_cyc = '0; m_stb = '0; ack_en = 1'b0;
    step();
    #1 check("t1_release_gnt", 32'(gnt_o), 32'h0);

    // Contention: strictly alternating grants starting from m0
    do_reset();
    for (int r = 0; r < 4; r++) begin
      m_cyc = 2'b11;
      step();
      #1 check($sformatf("t2_round%0d_gnt", r), 32'(gnt_o), (r % 2 == 0) ? 32'h1 : 32'h2);
      m_cyc = 2'b00;
      step();
      #1 check($sformatf("t2_round%0d_dead", r), 32'(gnt_o), 32'h0);
    end

    // Burst lock: m0 holds cyc for 4 beats while m1 waits
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11; ack_en = 1'b1;
    m_adr[59:30] = 30'h3F;
    step();
    for (int b = 0; b < 4; b++) begin
      m_adr[29:0] = 30'h20 + 30'(b);
      m_dat[31:0] = 32'hA5A50000 + 32'(b);
      #1;
      check($sformatf("t3_beat%0d_gnt", b), 32'(gnt_o), 32'h1);
      check($sformatf("t3_beat%0d_adr", b), 32'(s_adr_o), 32'h20 + 32'(b));
      check($sformatf("t3_beat%0d_ack", b), 32'(m_ack_o), 32'h1);
      step();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    #1 check("t3_dead_gnt", 32'(gnt_o), 32'h0);
    step();
    #1 check("t3_m1_gnt", 32'(gnt_o), 32'h2);
    check("t3_mem_beat2", mem[6'h22], 32'hA5A50002);
    m_cyc = '0; m_stb = '0; ack_en = 1'b0;
    step();

    // Timeout: m1 strobes with no slave ack
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("t4_c%0d_err", c), 32'(m_err_o), 32'h0);
      check($sformatf("t4_c%0d_scyc", c), 32'(s_cyc_o), 32'h1);
      step();
    end
    #1;
    check("t4_err", 32'(m_err_o), 32'h2);
    check("t4_err_scyc_sstb", 32'({s_cyc_o, s_stb_o}), 32'h0);
    m_cyc = '0; m_stb = '0; force_ack = 1'b1;
    #1 check("t4_err_late_ack", 32'(m_ack_o), 32'h0);
    step();
    #1;
    check("t4_idle_late_ack", 32'(m_ack_o), 32'h0);
    check("t4_idle_err", 32'(m_err_o), 32'h0);
    force_ack = 1'b0;

    // Async reset mid-burst
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[29:0] = 30'h11; ack_en = 1'b1;
    step();
    #1 check("t5_pre_ack", 32'(m_ack_o), 32'h1);
    #1 rst_i = 1'b1;
    #1;
    check("t5_rst_gnt", 32'(gnt_o), 32'h0);
    check("t5_rst_ack", 32'(m_ack_o), 32'h0);
    check("t5_rst_s", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'h0);
    check("t5_rst_sadr", 32'(s_adr_o), 32'h0);
    step();
    rst_i = 1'b0;
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    #1 check("t5_m1_gnt", 32'(gnt_o), 32'h2);
    m_cyc = '0; m_stb = '0; ack_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
